// File: rtl/led_blink_arbiter.sv
// Round-robin share of one LED between N_REQ requesters.
// Each grant plays a timed burst of blinks; idle shows a heartbeat.
module led_blink_arbiter #(
    parameter int CLK_HZ    = 16_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 4,
    parameter int ON_TICKS  = 200,
    parameter int OFF_TICKS = 200,
    parameter int GAP_TICKS = 800,
    parameter bit HB_EN     = 1'b1,
    parameter int HB_BIT    = 20
) (
    input  logic                   CLOCK,
    input  logic                   RESET_N,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] count,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   led
);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW   = $clog2(N_REQ);
    localparam int TM1  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TMAX = (TM1 > GAP_TICKS) ? TM1 : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    // ZERO is the single grant cycle of a zero-length burst
    typedef enum logic [2:0] {IDLE, ON, OFF, GAP, ZERO, DONE} state_t;

    state_t           state;
    logic [31:0]      hb_cnt;
    logic [31:0]      hb_nxt;
    logic [PW-1:0]    presc;
    logic [TW-1:0]    tcnt;
    logic [TW-1:0]    lim;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] cnt_sel;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    last;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    j;
    logic             win_vld;
    logic             tick;
    logic             phase_end;
    logic [N_REQ-1:0] win_oh;
    logic [N_REQ-1:0] idx_oh;

    assign hb_nxt = hb_cnt + 32'd1;
    assign tick   = (presc == PW'(DIV - 1));
    assign win_oh = ONE << win_idx;
    assign idx_oh = ONE << idx;

    // Walk downward so the slot right after last wins
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        j       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N_REQ);
            if (req[j]) begin
                win_vld = 1'b1;
                win_idx = j;
            end
        end
    end

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                cnt_sel = count[i*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        lim = '0;
        case (state)
            ON:      lim = TW'(ON_TICKS - 1);
            OFF:     lim = TW'(OFF_TICKS - 1);
            GAP:     lim = TW'(GAP_TICKS - 1);
            default: lim = '0;
        endcase
    end

    assign phase_end = tick && (tcnt == lim);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            led    <= 1'b0;
            hb_cnt <= '0;
            presc  <= '0;
            tcnt   <= '0;
            rem    <= '0;
            idx    <= '0;
            last   <= IW'(N_REQ - 1);
        end else begin
            hb_cnt <= hb_nxt;
            done   <= '0;
            presc  <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                tcnt <= tcnt + 1'b1;
            end
            if (phase_end) begin
                presc <= '0;
                tcnt  <= '0;
            end
            case (state)
                IDLE: begin
                    led <= HB_EN & hb_nxt[HB_BIT];
                    if (win_vld) begin
                        idx   <= win_idx;
                        grant <= win_oh;
                        busy  <= 1'b1;
                        rem   <= cnt_sel;
                        presc <= '0;
                        tcnt  <= '0;
                        if (cnt_sel != '0) begin
                            state <= ON;
                            led   <= 1'b1;
                        end else begin
                            state <= ZERO;
                            led   <= 1'b0;
                        end
                    end
                end
                ON: begin
                    if (phase_end) begin
                        rem   <= rem - 1'b1;
                        led   <= 1'b0;
                        state <= (rem == CNT_W'(1)) ? GAP : OFF;
                    end
                end
                OFF: begin
                    if (phase_end) begin
                        led   <= 1'b1;
                        state <= ON;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        done  <= idx_oh;
                        state <= DONE;
                    end
                end
                ZERO: begin
                    done  <= idx_oh;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    last  <= idx;
                    led   <= HB_EN & hb_nxt[HB_BIT];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: directed and random bursts checked
// against a per-burst timeline computed from the blink timing rules.
`timescale 1ns/1ps
module tb_led_blink_arbiter;
    localparam int CLK_HZ  = 16;
    localparam int TICK_HZ = 4;
    localparam int N       = 4;
    localparam int CW      = 4;
    localparam int ON_T    = 2;
    localparam int OFF_T   = 2;
    localparam int GAP_T   = 3;
    localparam int HBB     = 2;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int P_ON    = ON_T * DIV;
    localparam int P_OFF   = OFF_T * DIV;
    localparam int P_GAP   = GAP_T * DIV;

    logic          CLOCK   = 1'b0;
    logic          RESET_N = 1'b1;
    logic [N-1:0]  req     = '0;
    logic [N*CW-1:0] count = '0;
    logic [N-1:0]  grant, done, grant_h, done_h;
    logic          busy, led, busy_h, led_h;

    int errors = 0;
    int checks = 0;
    int t      = 0;
    bit m_act  = 1'b0;
    int m_idx  = 0;
    int m_cnt  = 0;
    int m_start = 0;
    int m_last = N - 1;
    bit auto_drop = 1'b0;

    led_blink_arbiter #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_REQ(N), .CNT_W(CW),
        .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T),
        .HB_EN(1'b0), .HB_BIT(20)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .req(req), .count(count),
        .grant(grant), .done(done), .busy(busy), .led(led)
    );

    led_blink_arbiter #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_REQ(N), .CNT_W(CW),
        .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T),
        .HB_EN(1'b1), .HB_BIT(HBB)
    ) dut_hb (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .req(req), .count(count),
        .grant(grant_h), .done(done_h), .busy(busy_h), .led(led_h)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic int blen(int c);
        if (c == 0) return 2;
        return c * P_ON + (c - 1) * P_OFF + P_GAP + 1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: observed %0h expected %0h",
                   tag, t, obs, exp);
        end
    endtask

    task automatic model_edge();
        int jj;
        bit f;
        f = 1'b0;
        t++;
        if (m_act) begin
            if (t - 1 - m_start == blen(m_cnt) - 1) begin
                m_act  = 1'b0;
                m_last = m_idx;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                jj = (m_last + k) % N;
                if (!f && req[jj]) begin
                    f     = 1'b1;
                    m_idx = jj;
                end
            end
            m_act   = 1'b1;
            m_start = t;
            m_cnt   = int'((count >> (m_idx * CW)) & ((1 << CW) - 1));
        end
    endtask

    task automatic check_all();
        int off;
        int c;
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        logic el;
        logic ehl;
        eg = '0;
        ed = '0;
        el = 1'b0;
        if (m_act) begin
            off = t - m_start;
            c = m_cnt;
            eg[m_idx] = 1'b1;
            if (off == blen(c) - 1) ed = eg;
            el = (c != 0) && (off < c * P_ON + (c - 1) * P_OFF)
                 && ((off % (P_ON + P_OFF)) < P_ON);
            ehl = el;
        end else begin
            ehl = ((t >> HBB) & 1) != 0;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("done", 32'(done), 32'(ed));
        chk("busy", 32'(busy), 32'(m_act));
        chk("led", 32'(led), 32'(el));
        chk("grant_hb", 32'(grant_h), 32'(eg));
        chk("done_hb", 32'(done_h), 32'(ed));
        chk("busy_hb", 32'(busy_h), 32'(m_act));
        chk("led_hb", 32'(led_h), 32'(ehl));
        if (auto_drop && ed != '0) req = req & ~ed;
    endtask

    task automatic cycle();
        @(posedge CLOCK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic run_idle(int limit);
        int k;
        k = 0;
        while (k < limit) begin
            cycle();
            k++;
            if (!m_act) break;
        end
    endtask

    task automatic do_reset(int n);
        RESET_N = 1'b0;
        t = 0;
        m_act = 1'b0;
        m_last = N - 1;
        #1;
        check_all();
        repeat (n) @(posedge CLOCK);
        #1;
        check_all();
        RESET_N = 1'b1;
    endtask

    initial begin
        #2;
        do_reset(2);

        // single 3-blink burst on requester 0
        auto_drop = 1'b1;
        count = 16'h0003;
        req = 4'b0001;
        run_idle(200);
        run(3);

        // all four requesting, count 1 each, rotation
        auto_drop = 1'b0;
        count = 16'h1111;
        req = 4'b1111;
        run(5 * 22);
        req = 4'b0000;
        run_idle(100);
        run(2);

        // zero-length burst
        auto_drop = 1'b1;
        count = 16'h0000;
        req = 4'b0100;
        run_idle(10);
        run(3);

        // reset in the middle of an ON phase
        count = 16'h0002;
        req = 4'b0001;
        run(4);
        do_reset(1);
        run_idle(100);
        run(2);

        // request dropped shortly after grant
        auto_drop = 1'b0;
        count = 16'h0002;
        req = 4'b0001;
        run(4);
        req = 4'b0000;
        run_idle(100);
        run(10);

        // largest count
        auto_drop = 1'b1;
        count = 16'hF000;
        req = 4'b1000;
        run_idle(400);
        run(2);

        // heartbeat, then a burst over it, then heartbeat again
        run(24);
        count = 16'h0001;
        req = 4'b0001;
        run_idle(50);
        run(24);

        // random traffic
        auto_drop = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) req = N'($urandom());
            if ($urandom_range(15) == 0) begin
                count = 16'($urandom());
            end else if ($urandom_range(3) == 0) begin
                count = 16'($urandom() & 32'h3333);
            end
            cycle();
        end
        req = '0;
        run_idle(600);
        run(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
